// File: rtl/alu_iter.sv
// Handshaked ALU for the multicycle ARM core: single-cycle logic/arithmetic ops,
// iterative shift-add MUL and restoring UDIV, registered result and {N,Z,C,V} flags.
module alu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [1:0]       state_dbg
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // out_valid with result/flags stays stable until out_ready takes it.
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_ORR = 4'd3,
                           OP_ADC = 4'd4, OP_SBC = 4'd5, OP_EOR = 4'd6, OP_BIC = 4'd7,
                           OP_MUL = 4'd8, OP_DIV = 4'd9;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_BPC - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_nx;

    // acc: product accumulator / partial remainder; opa: multiplicand / dividend-quotient
    // shifter; opb: multiplier shifter / divisor.
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, opa, opb;

    logic             accept, invert, cin, is_arith, ovf;
    logic [WIDTH-1:0] bb, simple_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_acc_nx, div_rem_nx, div_q_nx;
    logic [WIDTH:0]   rem_sh, diff;
    logic             div_ge;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign state_dbg = state;

    always_comb begin
        invert = (op == OP_SUB) || (op == OP_SBC);
        bb     = invert ? ~b : b;
        case (op)
            OP_SUB:         cin = 1'b1;
            OP_ADC, OP_SBC: cin = carry_in;
            default:        cin = 1'b0;
        endcase
        sum      = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
        ovf      = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: simple_res = sum[WIDTH-1:0];
            OP_AND:  simple_res = a & b;
            OP_ORR:  simple_res = a | b;
            OP_EOR:  simple_res = a ^ b;
            OP_BIC:  simple_res = a & ~b;
            default: simple_res = '0;  // UDIV by zero and reserved ops
        endcase
    end

    always_comb begin
        mul_acc_nx = acc;
        for (int k = 0; k < MUL_BPC; k++) begin
            if (opb[k]) mul_acc_nx = mul_acc_nx + (opa << k);
        end
        rem_sh     = {acc, opa[WIDTH-1]};
        diff       = rem_sh - {1'b0, opb};
        div_ge     = !diff[WIDTH];
        div_rem_nx = div_ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_q_nx   = {opa[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            if (op == OP_MUL)                    state_nx = S_MUL;
            else if (op == OP_DIV && b != '0)    state_nx = S_DIV;
            else                                 state_nx = S_DONE;
        end else begin
            case (state)
                S_MUL:   if (cnt == MUL_LAST) state_nx = S_DONE;
                S_DIV:   if (cnt == DIV_LAST) state_nx = S_DONE;
                S_DONE:  if (out_ready)       state_nx = S_IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt <= '0;
                acc <= '0;
                opa <= a;
                opb <= b;
                if (!(op == OP_MUL || (op == OP_DIV && b != '0))) begin
                    result <= simple_res;
                    flags  <= {simple_res[WIDTH-1], simple_res == '0,
                               is_arith & sum[WIDTH], is_arith & ovf};
                end
            end else if (state == S_MUL) begin
                cnt <= cnt + 1'b1;
                acc <= mul_acc_nx;
                opa <= opa << MUL_BPC;
                opb <= opb >> MUL_BPC;
                if (cnt == MUL_LAST) begin
                    result <= mul_acc_nx;
                    flags  <= {mul_acc_nx[WIDTH-1], mul_acc_nx == '0, 2'b00};
                end
            end else if (state == S_DIV) begin
                cnt <= cnt + 1'b1;
                acc <= div_rem_nx;
                opa <= div_q_nx;
                if (cnt == DIV_LAST) begin
                    result <= div_q_nx;
                    flags  <= {div_q_nx[WIDTH-1], div_q_nx == '0, 2'b00};
                end
            end
        end
    end
endmodule
